// File: rtl/alu_output_monitor.sv
// Runtime checker for the 4-bit ALU: recomputes each sampled transaction with a golden model,
// counts mismatches, logs the first failure and raises a sticky alarm at THRESHOLD.
module alu_output_monitor #(
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [1:0]       op,
    input  logic [3:0]       dut_result,
    input  logic             dut_carry,
    input  logic             dut_zero,
    input  logic             dut_overflow,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [3:0]       mismatch_flags,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             alarm,
    output logic             log_valid,
    output logic [14:0]      log_data,
    output logic [1:0]       state
);

    // state | meaning
    // IDLE  | monitoring off, nothing captured
    // ARMED | capturing and checking transactions
    // ALARM | threshold reached; checking continues until clear/reset
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        ALARM = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

    state_t     state_q;
    logic       s1_valid;
    logic [3:0] s1_a;
    logic [3:0] s1_b;
    logic [1:0] s1_op;
    logic [3:0] s1_res;
    logic       s1_c;
    logic       s1_z;
    logic       s1_v;

    logic [4:0]       g_sum;
    logic             g_v;
    logic [3:0]       flags_next;
    logic             mis_next;
    logic [CNT_W-1:0] count_next;
    logic             alarm_next;

    assign state = state_q;

    always_comb begin
        g_sum = 5'd0;
        g_v   = 1'b0;
        case (s1_op)
            2'b00: begin
                g_sum = {1'b0, s1_a} + {1'b0, s1_b};
                g_v   = (s1_a[3] == s1_b[3]) && (g_sum[3] != s1_a[3]);
            end
            2'b01: begin
                // carry out of A + ~B + 1 is the "no borrow" indication
                g_sum = {1'b0, s1_a} + {1'b0, ~s1_b} + 5'd1;
                g_v   = (s1_a[3] != s1_b[3]) && (g_sum[3] != s1_a[3]);
            end
            2'b10:   g_sum = {1'b0, s1_a & s1_b};
            default: g_sum = {1'b0, s1_a | s1_b};
        endcase
    end

    always_comb begin
        flags_next = {g_sum[3:0] != s1_res,
                      g_sum[4] != s1_c,
                      (g_sum[3:0] == 4'd0) != s1_z,
                      g_v != s1_v};
        mis_next   = s1_valid && (flags_next != 4'd0);
        count_next = mismatch_count;
        if (mis_next && (mismatch_count != CNT_MAX))
            count_next = mismatch_count + 1'b1;
        alarm_next = alarm || (count_next >= THR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            s1_valid       <= 1'b0;
            s1_a           <= 4'd0;
            s1_b           <= 4'd0;
            s1_op          <= 2'd0;
            s1_res         <= 4'd0;
            s1_c           <= 1'b0;
            s1_z           <= 1'b0;
            s1_v           <= 1'b0;
            chk_valid      <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_flags <= 4'd0;
            mismatch_count <= '0;
            alarm          <= 1'b0;
            log_valid      <= 1'b0;
            log_data       <= 15'd0;
        end else if (clear) begin
            state_q        <= enable ? ARMED : IDLE;
            s1_valid       <= 1'b0;
            s1_a           <= 4'd0;
            s1_b           <= 4'd0;
            s1_op          <= 2'd0;
            s1_res         <= 4'd0;
            s1_c           <= 1'b0;
            s1_z           <= 1'b0;
            s1_v           <= 1'b0;
            chk_valid      <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_flags <= 4'd0;
            mismatch_count <= '0;
            alarm          <= 1'b0;
            log_valid      <= 1'b0;
            log_data       <= 15'd0;
        end else begin
            s1_valid <= in_valid && (state_q != IDLE);
            if (in_valid && (state_q != IDLE)) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_op  <= op;
                s1_res <= dut_result;
                s1_c   <= dut_carry;
                s1_z   <= dut_zero;
                s1_v   <= dut_overflow;
            end

            chk_valid      <= s1_valid;
            mismatch       <= mis_next;
            mismatch_flags <= s1_valid ? flags_next : 4'd0;
            mismatch_count <= count_next;
            alarm          <= alarm_next;

            if (mis_next && !log_valid) begin
                log_valid <= 1'b1;
                log_data  <= {s1_op, s1_a, s1_b, s1_res, s1_c};
            end

            // an entry still in flight after enable drops may cross the threshold
            case (state_q)
                IDLE: begin
                    if (alarm_next)  state_q <= ALARM;
                    else if (enable) state_q <= ARMED;
                end
                ARMED: begin
                    if (alarm_next)   state_q <= ALARM;
                    else if (!enable) state_q <= IDLE;
                end
                ALARM:   state_q <= ALARM;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_output_monitor.sv
// Scoreboard bench for alu_output_monitor: default instance and a CNT_W=2/THRESHOLD=3
// instance share all stimulus; a monitor pops expectations on every chk_valid.
module tb_alu_output_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic enable, clear, in_valid;
    logic [3:0] A, B, dut_result;
    logic [1:0] op;
    logic dut_carry, dut_zero, dut_overflow;

    logic        chk_valid1, mismatch1, alarm1, log_valid1;
    logic [3:0]  flags1;
    logic [7:0]  count1;
    logic [14:0] log_data1;
    logic [1:0]  state1;

    logic        chk_valid2, mismatch2, alarm2, log_valid2;
    logic [3:0]  flags2;
    logic [1:0]  count2;
    logic [14:0] log_data2;
    logic [1:0]  state2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_output_monitor u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .in_valid(in_valid),
        .A(A), .B(B), .op(op), .dut_result(dut_result), .dut_carry(dut_carry),
        .dut_zero(dut_zero), .dut_overflow(dut_overflow),
        .chk_valid(chk_valid1), .mismatch(mismatch1), .mismatch_flags(flags1),
        .mismatch_count(count1), .alarm(alarm1), .log_valid(log_valid1),
        .log_data(log_data1), .state(state1)
    );

    alu_output_monitor #(.CNT_W(2), .THRESHOLD(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .in_valid(in_valid),
        .A(A), .B(B), .op(op), .dut_result(dut_result), .dut_carry(dut_carry),
        .dut_zero(dut_zero), .dut_overflow(dut_overflow),
        .chk_valid(chk_valid2), .mismatch(mismatch2), .mismatch_flags(flags2),
        .mismatch_count(count2), .alarm(alarm2), .log_valid(log_valid2),
        .log_data(log_data2), .state(state2)
    );

    typedef struct packed {
        logic [3:0]  flags;
        logic [7:0]  cnt1;
        logic        alm1;
        logic        logv1;
        logic [14:0] logd1;
        logic [1:0]  cnt2;
        logic        alm2;
        logic        logv2;
        logic [14:0] logd2;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0]  m_cnt1;
    logic [1:0]  m_cnt2;
    logic        m_logv1, m_logv2;
    logic [14:0] m_logd1, m_logd2;
    int          n_checked = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt1 = 8'd0;  m_cnt2 = 2'd0;
        m_logv1 = 1'b0; m_logv2 = 1'b0;
        m_logd1 = 15'd0; m_logd2 = 15'd0;
    endtask

    // returns {r,c,z,v}
    function automatic logic [6:0] gold(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        int s, sr, sa, sb;
        logic [3:0] r;
        logic c, v;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        c = 1'b0; v = 1'b0;
        case (o)
            2'b00: begin s = int'(a) + int'(b); sr = sa + sb;
                   r = s[3:0]; c = s[4]; v = (sr > 7) || (sr < -8); end
            2'b01: begin s = int'(a) + (15 - int'(b)) + 1; sr = sa - sb;
                   r = s[3:0]; c = s[4]; v = (sr > 7) || (sr < -8); end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {r, c, (r == 4'd0), v};
    endfunction

    task automatic drive(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] r, input logic c, input logic z, input logic v);
        in_valid = 1'b1; op = o; A = a; B = b;
        dut_result = r; dut_carry = c; dut_zero = z; dut_overflow = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] r, input logic c, input logic z, input logic v,
                        input logic [3:0] exp_flags);
        exp_t e;
        if (exp_flags != 4'd0) begin
            if (!m_logv1) begin m_logv1 = 1'b1; m_logd1 = {o, a, b, r, c}; end
            if (!m_logv2) begin m_logv2 = 1'b1; m_logd2 = {o, a, b, r, c}; end
            if (m_cnt1 != 8'hFF) m_cnt1 = m_cnt1 + 8'd1;
            if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
        end
        e.flags = exp_flags;
        e.cnt1 = m_cnt1; e.alm1 = (m_cnt1 >= 8'd1); e.logv1 = m_logv1; e.logd1 = m_logd1;
        e.cnt2 = m_cnt2; e.alm2 = (m_cnt2 >= 2'd3); e.logv2 = m_logv2; e.logd2 = m_logd2;
        exp_q.push_back(e);
        drive(o, a, b, r, c, z, v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_valid1 || chk_valid2) begin
            if (exp_q.size() == 0) begin
                tests++; failed++;
                $display("FAIL unexpected_chk_valid: got %0b/%0b expected 0/0 at %0t",
                         chk_valid1, chk_valid2, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checked++;
                chk("chk_valid1", chk_valid1, 1);
                chk("chk_valid2", chk_valid2, 1);
                chk("mismatch1", mismatch1, (e.flags != 4'd0));
                chk("flags1", flags1, e.flags);
                chk("flags2", flags2, e.flags);
                chk("count1", count1, e.cnt1);
                chk("alarm1", alarm1, e.alm1);
                chk("log_valid1", log_valid1, e.logv1);
                chk("log_data1", log_data1, e.logd1);
                chk("count2", count2, e.cnt2);
                chk("alarm2", alarm2, e.alm2);
                chk("log_data2", log_data2, e.logd2);
            end
        end
    end

    initial begin
        logic [6:0] g;
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
        A = 4'd0; B = 4'd0; op = 2'd0; dut_result = 4'd0;
        dut_carry = 1'b0; dut_zero = 1'b0; dut_overflow = 1'b0;
        model_reset();
        idle(2);
        chk("rst_count1", count1, 0);
        chk("rst_alarm1", alarm1, 0);
        chk("rst_log1", {log_valid1, log_data1}, 0);
        chk("rst_out1", {chk_valid1, mismatch1, flags1}, 0);
        chk("rst_state1", state1, 0);
        chk("rst_state2", state2, 0);

        rst_n = 1'b1;
        idle(1);
        chk("idle_hold", state1, 0);
        enable = 1'b1;
        idle(1);
        chk("armed1", state1, 1);
        chk("armed2", state2, 1);

        for (int o = 0; o < 4; o++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    g = gold(o[1:0], a[3:0], b[3:0]);
                    send(o[1:0], a[3:0], b[3:0], g[6:3], g[2], g[1], g[0], 4'b0000);
                end
        idle(3);
        chk("exhaustive_checks", n_checked, 1024);
        chk("clean_count1", count1, 0);

        // ADD 7+1 with overflow suppressed
        send(2'b00, 4'd7, 4'd1, 4'd8, 1'b0, 1'b0, 1'b0, 4'b0001);
        idle(3);
        chk("add_count1", count1, 1);
        chk("add_alarm1", alarm1, 1);
        chk("add_log1", log_data1, 15'h0E30);
        chk("add_state1", state1, 2);
        chk("add_alarm2", alarm2, 0);
        chk("add_state2", state2, 1);

        // SUB 0-1 correct, then result corrupted
        send(2'b01, 4'd0, 4'd1, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
        send(2'b01, 4'd0, 4'd1, 4'hE, 1'b0, 1'b0, 1'b0, 4'b1000);
        idle(3);
        chk("sub_count1", count1, 2);
        chk("sub_log1_kept", log_data1, 15'h0E30);

        clear = 1'b1;
        model_reset();
        idle(1);
        clear = 1'b0;
        chk("clr_count1", count1, 0);
        chk("clr_state1", state1, 1);
        chk("clr_state2", state2, 1);

        // five back-to-back mismatches into the saturating 2-bit instance
        send(2'b10, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0100);
        send(2'b11, 4'd3, 4'd4, 4'd7, 1'b0, 1'b1, 1'b0, 4'b0010);
        send(2'b00, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4'b1000);
        send(2'b01, 4'd5, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 4'b0100);
        send(2'b00, 4'd8, 4'd8, 4'd0, 1'b1, 1'b1, 1'b0, 4'b0001);
        idle(3);
        chk("sat_count2", count2, 3);
        chk("sat_alarm2", alarm2, 1);
        chk("sat_log2", log_data2, 15'h5FFF);
        chk("sat_state2", state2, 2);
        chk("sat_count1", count1, 5);

        // clear on the edge that would register a mismatching check
        drive(2'b00, 4'd1, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        in_valid = 1'b1; dut_result = 4'd9;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        model_reset();
        idle(3);
        chk("clrmis_count1", count1, 0);
        chk("clrmis_alarm1", alarm1, 0);
        chk("clrmis_logv1", log_valid1, 0);
        chk("clrmis_state1", state1, 1);
        chk("clrmis_count2", count2, 0);

        // async reset with an entry in S1
        drive(2'b00, 4'd1, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        enable = 1'b0;
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(4);
        chk("rstmid_out1", {chk_valid1, mismatch1, flags1, alarm1, log_valid1}, 0);
        chk("rstmid_count1", count1, 0);
        chk("rstmid_log1", log_data1, 0);
        chk("rstmid_state1", state1, 0);
        chk("rstmid_state2", state2, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
